pixel_stream_fb_writer: RTL and testbench
=========================================

// Module: pixel_stream_fb_writer
// PURPOSE
// - Consumer end of the (x, y) coordinate stream emitted by the shape generators (rectangle, line, circle).
// - Accepts one coordinate per valid/ready handshake and buffers it in a small FIFO.
// - Clips against the frame bounds, converts (x, y) to a linear framebuffer address and issues single-word writes to the framebuffer port.
// - Raises _done once the producer has signalled its end and every buffered pixel is written or clipped.
// PARAMETERS
// - FB_WIDTH   320  frame width in pixels; x must be < FB_WIDTH
// - FB_HEIGHT  240  frame height in pixels; y must be < FB_HEIGHT
// - ADDR_W     17   framebuffer address width; must satisfy FB_WIDTH*FB_HEIGHT <= 2**ADDR_W
// - DATA_W     8    pixel colour width
// - FIFO_DEPTH 4    coordinate buffer entries; power of two, >= 2
// PORTS
// - _clock       in   1       single clock, all logic on posedge
// - _reset_n     in   1       asynchronous active-low reset
// - _start       in   1       1-cycle pulse: clear counters/FIFO, latch colour, enter RUN
// - colour       in   DATA_W  pixel value, sampled on _start
// - in_valid     in   1       producer has a coordinate on in_x/in_y
// - in_ready     out  1       sink can accept; transfer when in_valid & in_ready
// - in_x         in   32      x coordinate, unsigned
// - in_y         in   32      y coordinate, unsigned
// - in_last      in   1       producer finished (generator _done); level, sampled in RUN
// - mem_we       out  1       write request; held with addr/data until mem_ready
// - mem_addr     out  ADDR_W  y*FB_WIDTH + x
// - mem_data     out  DATA_W  latched colour
// - mem_ready    in   1       framebuffer accepts the write this cycle when mem_we & mem_ready
// - pix_count    out  32      pixels written since _start
// - clip_count   out  32      coordinates dropped since _start
// - _done        out  1       frame complete; holds until next _start
// BEHAVIOUR
// Reset
// - _reset_n low asynchronously forces state IDLE and clears the FIFO.
// - All outputs are 0: in_ready, mem_we, mem_addr, mem_data, pix_count, clip_count, _done.
// States
// - IDLE: on _start go to RUN.
// - RUN: on in_last = 1 go to DRAIN; in_ready is deasserted from the next cycle.
// - DRAIN: when the FIFO is empty and no write is outstanding, go to DONE.
// - DONE: _done = 1. On _start go to RUN and clear _done.
// Input side
// - in_ready = (state == RUN) & !fifo_full.
// - A transfer and in_last in the same cycle: that coordinate is still accepted.
// Clipping
// - Applied at FIFO pop.
// - Coordinate is dropped if in_x >= FB_WIDTH or in_y >= FB_HEIGHT (full 32-bit unsigned compare).
// - A dropped coordinate increments clip_count, issues no write and consumes 1 cycle.
// Write stage
// - One registered stage: pop -> mem_addr/mem_we valid on the next cycle.
// - Latency from input transfer to mem_we is 2 cycles when the FIFO is empty.
// - The address product is computed at ADDR_W+1 bits and truncated to ADDR_W; clipping guarantees no overflow.
// - When mem_we & !mem_ready: addr, data and we hold stable and no pop occurs (backpressure).
// - Full-rate streaming: with mem_ready stuck at 1, one pixel per cycle.
// - pix_count increments on each mem_we & mem_ready.
// FIFO
// - Simultaneous push and pop while full is allowed (pop frees the slot).
// - Pointers wrap modulo FIFO_DEPTH.
// - Count width is clog2(FIFO_DEPTH)+1.
// _start mid-frame (RUN or DRAIN)
// - Synchronously flushes the FIFO and drops any outstanding write (mem_we = 0 next cycle).
// - Zeroes counters, relatches colour and re-enters RUN.
// STRUCTURE
// - Package pixel_stream_pkg: typedef enum {IDLE, RUN, DRAIN, DONE} fbw_state_t; typedef struct {x, y} coord_t.
// - Sub-module coord_fifo (coord_t, DEPTH): push/pop/full/empty/flush.
// - Clip, address and write logic stay in the top module.
// TESTING
// - Reset: _reset_n = 0 mid-RUN -> all outputs 0 in the same cycle, state IDLE.
// - Basic stream: colour = 0x5A, pixels (3,2), (0,0), (319,239), mem_ready = 1, then in_last -> addrs 643, 0, 76799; data 0x5A; pix_count = 3; _done asserted.
// - Clip: (320,0), (0,240), (0xFFFFFFFF,5), (10,1) -> one write to addr 330; clip_count = 3, pix_count = 1.
// - Backpressure: mem_ready = 0 for 6 cycles with 6 valid inputs -> FIFO fills after 4+1, in_ready = 0, mem_addr stable; on release all 6 written in order.
// - Abort: _start issued after 2 of 5 pixels -> counters reset, no stale write; a new 3-pixel frame gives pix_count = 3.
// - in_last together with the final transfer -> that pixel is written before _done rises.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream sink: FSM state encoding and the coordinate record.
package pixel_stream_pkg;

   localparam int COORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fbw_state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_t;

endpackage

// File: rtl/pixel_stream_fb_writer_coord_fifo.sv
// First-word-fall-through coordinate buffer with synchronous flush; push while full is
// accepted only when a pop frees the slot in the same cycle.
module coord_fifo
   import pixel_stream_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   i_clock,
   input  logic   i_reset_n,
   input  logic   i_flush,
   input  logic   i_push,
   input  coord_t i_data,
   input  logic   i_pop,
   output coord_t o_data,
   output logic   o_full,
   output logic   o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   coord_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge i_clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/pixel_stream_fb_writer.sv
// Sink for shape-generator (x, y) streams: buffers coordinates, clips to the frame,
// and issues single-word framebuffer writes of the colour latched at start.
module pixel_stream_fb_writer
   import pixel_stream_pkg::*;
#(
   parameter int FB_WIDTH   = 320,
   parameter int FB_HEIGHT  = 240,
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_start,
   input  logic [DATA_W-1:0]  i_colour,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [31:0]        i_in_x,
   input  logic [31:0]        i_in_y,
   input  logic               i_in_last,
   output logic               o_mem_we,
   output logic [ADDR_W-1:0]  o_mem_addr,
   output logic [DATA_W-1:0]  o_mem_data,
   input  logic               i_mem_ready,
   output logic [31:0]        o_pix_count,
   output logic [31:0]        o_clip_count,
   output logic               o_done
);

   localparam logic [ADDR_W:0] LP_FB_W = (ADDR_W+1)'(FB_WIDTH);

   fbw_state_t         r_state;
   fbw_state_t         w_state_nxt;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_colour;
   logic [31:0]        r_pix_count;
   logic [31:0]        r_clip_count;

   coord_t             w_push_data;
   coord_t             w_head;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_clip;
   logic               w_wr_done;
   logic               w_stage_free;
   logic [ADDR_W:0]    w_addr_full;

   assign o_in_ready   = (r_state == RUN) && !w_full;
   assign w_push       = i_in_valid && o_in_ready;
   assign w_push_data  = '{x: i_in_x, y: i_in_y};

   coord_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_flush   (i_start),
      .i_push    (w_push),
      .i_data    (w_push_data),
      .i_pop     (w_pop),
      .o_data    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign w_wr_done    = r_mem_we && i_mem_ready;
   assign w_stage_free = !r_mem_we || i_mem_ready;
   assign w_pop        = !w_empty && w_stage_free && !i_start &&
                         ((r_state == RUN) || (r_state == DRAIN));

   // Product at ADDR_W+1 bits; the top bit can only be set by an out-of-frame
   // coordinate, so it is folded into the clip decision as a backstop.
   assign w_addr_full  = (ADDR_W+1)'(w_head.y) * LP_FB_W + (ADDR_W+1)'(w_head.x);
   assign w_clip       = (w_head.x >= 32'(FB_WIDTH)) || (w_head.y >= 32'(FB_HEIGHT)) ||
                         w_addr_full[ADDR_W];

   always_comb begin
      w_state_nxt = r_state;
      if (i_start) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            RUN:     if (i_in_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_empty && !r_mem_we) w_state_nxt = DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   // Write stage: a popped in-frame coordinate becomes a request on the next cycle
   // and is held until the framebuffer accepts it.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_colour     <= '0;
         r_pix_count  <= '0;
         r_clip_count <= '0;
      end else if (i_start) begin
         r_mem_we     <= 1'b0;
         r_colour     <= i_colour;
         r_pix_count  <= '0;
         r_clip_count <= '0;
      end else begin
         if (w_pop && !w_clip) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_addr_full[ADDR_W-1:0];
         end else if (w_wr_done) begin
            r_mem_we   <= 1'b0;
         end
         if (w_wr_done)         r_pix_count  <= r_pix_count + 32'd1;
         if (w_pop && w_clip)   r_clip_count <= r_clip_count + 32'd1;
      end
   end

   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_data   = r_colour;
   assign o_pix_count  = r_pix_count;
   assign o_clip_count = r_clip_count;
   assign o_done       = (r_state == DONE);

endmodule

// File: tb/tb_pixel_stream_fb_writer.sv
// Scoreboard bench for pixel_stream_fb_writer: expected writes are queued as coordinates
// are accepted and matched against the write log captured from the framebuffer port.
module tb_pixel_stream_fb_writer;

   localparam int TB_W = 320;
   localparam int TB_H = 240;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic [7:0]   i_colour = '0;
   logic         i_in_valid = 1'b0;
   logic [31:0]  i_in_x = '0;
   logic [31:0]  i_in_y = '0;
   logic         i_in_last = 1'b0;
   logic         i_mem_ready = 1'b0;
   logic         o_in_ready;
   logic         o_mem_we;
   logic [16:0]  o_mem_addr;
   logic [7:0]   o_mem_data;
   logic [31:0]  o_pix_count;
   logic [31:0]  o_clip_count;
   logic         o_done;

   int           vectors = 0;
   int           miscompares = 0;
   logic [7:0]   exp_colour = '0;
   logic [24:0]  exp_q [$];
   logic [16:0]  got_addr [0:255];
   logic [7:0]   got_data [0:255];
   int           got_n = 0;
   int           rd_n = 0;

   pixel_stream_fb_writer dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_start      (i_start),
      .i_colour     (i_colour),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_in_x       (i_in_x),
      .i_in_y       (i_in_y),
      .i_in_last    (i_in_last),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_data   (o_mem_data),
      .i_mem_ready  (i_mem_ready),
      .o_pix_count  (o_pix_count),
      .o_clip_count (o_clip_count),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_mem_we && i_mem_ready && got_n < 256) begin
         got_addr[got_n] <= o_mem_addr;
         got_data[got_n] <= o_mem_data;
         got_n           <= got_n + 1;
      end
   end

   task automatic do_start(input logic [7:0] c);
      i_start = 1'b1;
      i_colour = c;
      exp_colour = c;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic drive_pixel(input logic [31:0] x, input logic [31:0] y, input logic last,
                              output bit ok);
      bit rdy;
      ok = 1'b0;
      i_in_valid = 1'b1;
      i_in_x = x;
      i_in_y = y;
      i_in_last = last;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         rdy = o_in_ready;
         @(posedge clk); #1;
         if (rdy) ok = 1'b1;
      end
      i_in_valid = 1'b0;
      i_in_last = 1'b0;
      if (ok && x < TB_W && y < TB_H) exp_q.push_back({exp_colour, 17'(y * TB_W + x)});
   endtask

   task automatic raise_last;
      i_in_last = 1'b1;
      @(posedge clk); #1;
      i_in_last = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk); #1;
         if (o_done) ok = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      bit ok;
      vectors++;
      if ({o_in_ready, o_mem_we, o_mem_addr, o_mem_data, o_pix_count, o_clip_count, o_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_por: rdy=%b we=%b addr=%0d data=%h pix=%0d clip=%0d done=%b, all zero required",
                  o_in_ready, o_mem_we, o_mem_addr, o_mem_data, o_pix_count, o_clip_count, o_done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      i_mem_ready = 1'b0;
      do_start(8'hA5);
      drive_pixel(32'd5, 32'd5, 1'b0, ok);
      @(posedge clk); #1;
      vectors++;
      if (!ok || o_mem_we !== 1'b1 || o_mem_addr !== 17'd1605 || o_in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_prep: ok=%b we=%b addr=%0d rdy=%b, required 1 1 1605 1", ok, o_mem_we, o_mem_addr, o_in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_in_ready, o_mem_we, o_mem_addr, o_mem_data, o_pix_count, o_clip_count, o_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_async: rdy=%b we=%b addr=%0d data=%h pix=%0d clip=%0d done=%b, all zero required",
                  o_in_ready, o_mem_we, o_mem_addr, o_mem_data, o_pix_count, o_clip_count, o_done);
      end
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (o_in_ready !== 1'b0 || o_done !== 1'b0 || got_n != 0) begin
         miscompares++;
         $display("FAIL reset_idle: rdy=%b done=%b writes=%0d, required 0 0 0", o_in_ready, o_done, got_n);
      end
   endtask

   task automatic test_basic;
      bit ok, all_ok;
      logic [24:0] e;
      all_ok = 1'b1;
      i_mem_ready = 1'b1;
      do_start(8'h5A);
      drive_pixel(32'd3, 32'd2, 1'b0, ok);     all_ok &= ok;
      drive_pixel(32'd0, 32'd0, 1'b0, ok);     all_ok &= ok;
      drive_pixel(32'd319, 32'd239, 1'b0, ok); all_ok &= ok;
      raise_last;
      wait_done(50, ok);
      vectors++;
      if (!all_ok || !ok) begin
         miscompares++;
         $display("FAIL basic_handshake: accepted=%b done=%b, required 1 1", all_ok, ok);
      end
      vectors++;
      if (o_pix_count !== 32'd3 || o_clip_count !== 32'd0 || o_done !== 1'b1 || o_in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_counts: pix=%0d clip=%0d done=%b rdy=%b, required 3 0 1 0",
                  o_pix_count, o_clip_count, o_done, o_in_ready);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (rd_n >= got_n) begin
            miscompares++;
            $display("FAIL basic_write: no write seen, required addr %0d", e[16:0]);
         end else begin
            if (got_addr[rd_n] !== e[16:0] || got_data[rd_n] !== e[24:17]) begin
               miscompares++;
               $display("FAIL basic_write: addr %0d data %h, required addr %0d data %h",
                        got_addr[rd_n], got_data[rd_n], e[16:0], e[24:17]);
            end
            rd_n++;
         end
      end
      vectors++;
      if (got_n != rd_n) begin
         miscompares++;
         $display("FAIL basic_extra: %0d writes seen, %0d required", got_n, rd_n);
         rd_n = got_n;
      end
   endtask

   task automatic test_clip;
      bit ok, all_ok;
      logic [24:0] e;
      all_ok = 1'b1;
      i_mem_ready = 1'b1;
      do_start(8'h3C);
      drive_pixel(32'd320, 32'd0, 1'b0, ok);        all_ok &= ok;
      drive_pixel(32'd0, 32'd240, 1'b0, ok);        all_ok &= ok;
      drive_pixel(32'hFFFF_FFFF, 32'd5, 1'b0, ok);  all_ok &= ok;
      drive_pixel(32'd10, 32'd1, 1'b0, ok);         all_ok &= ok;
      raise_last;
      wait_done(50, ok);
      vectors++;
      if (!all_ok || !ok || o_clip_count !== 32'd3 || o_pix_count !== 32'd1) begin
         miscompares++;
         $display("FAIL clip_counts: accepted=%b done=%b clip=%0d pix=%0d, required 1 1 3 1",
                  all_ok, ok, o_clip_count, o_pix_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (rd_n >= got_n) begin
            miscompares++;
            $display("FAIL clip_write: no write seen, required addr %0d", e[16:0]);
         end else begin
            if (got_addr[rd_n] !== e[16:0] || got_data[rd_n] !== e[24:17]) begin
               miscompares++;
               $display("FAIL clip_write: addr %0d data %h, required addr %0d data %h",
                        got_addr[rd_n], got_data[rd_n], e[16:0], e[24:17]);
            end
            rd_n++;
         end
      end
      vectors++;
      if (got_n != rd_n) begin
         miscompares++;
         $display("FAIL clip_extra: %0d writes seen, %0d required", got_n, rd_n);
         rd_n = got_n;
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] bx [0:7];
      logic [31:0] by [0:7];
      logic [16:0] held;
      logic [24:0] e;
      int          n_sent;
      bit          rdy, ok;
      bx = '{32'd10, 32'd11, 32'd300, 32'd0, 32'd319, 32'd50, 32'd0, 32'd0};
      by = '{32'd0, 32'd20, 32'd100, 32'd239, 32'd0, 32'd50, 32'd0, 32'd0};
      held = '0;
      n_sent = 0;
      i_mem_ready = 1'b0;
      do_start(8'hC3);
      for (int c = 0; c < 40 && n_sent < 6; c++) begin
         if (c == 8) begin
            vectors++;
            if (n_sent != 5 || o_in_ready !== 1'b0 || o_mem_we !== 1'b1 || o_mem_addr !== held ||
                held !== 17'd10) begin
               miscompares++;
               $display("FAIL bp_stall: sent=%0d rdy=%b we=%b addr=%0d held=%0d, required 5 0 1 10 10",
                        n_sent, o_in_ready, o_mem_we, o_mem_addr, held);
            end
            i_mem_ready = 1'b1;
         end
         i_in_valid = 1'b1;
         i_in_x = bx[n_sent];
         i_in_y = by[n_sent];
         @(negedge clk);
         rdy = o_in_ready;
         if (c == 2) held = o_mem_addr;
         @(posedge clk); #1;
         if (rdy) begin
            exp_q.push_back({exp_colour, 17'(by[n_sent] * TB_W + bx[n_sent])});
            n_sent++;
         end
      end
      i_in_valid = 1'b0;
      raise_last;
      wait_done(50, ok);
      vectors++;
      if (n_sent != 6 || !ok || o_pix_count !== 32'd6) begin
         miscompares++;
         $display("FAIL bp_release: sent=%0d done=%b pix=%0d, required 6 1 6", n_sent, ok, o_pix_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (rd_n >= got_n) begin
            miscompares++;
            $display("FAIL bp_write: no write seen, required addr %0d", e[16:0]);
         end else begin
            if (got_addr[rd_n] !== e[16:0] || got_data[rd_n] !== e[24:17]) begin
               miscompares++;
               $display("FAIL bp_write: addr %0d data %h, required addr %0d data %h",
                        got_addr[rd_n], got_data[rd_n], e[16:0], e[24:17]);
            end
            rd_n++;
         end
      end
      vectors++;
      if (got_n != rd_n) begin
         miscompares++;
         $display("FAIL bp_extra: %0d writes seen, %0d required", got_n, rd_n);
         rd_n = got_n;
      end
   endtask

   task automatic test_abort;
      bit ok, all_ok;
      logic [24:0] e;
      all_ok = 1'b1;
      i_mem_ready = 1'b1;
      do_start(8'h11);
      drive_pixel(32'd1, 32'd0, 1'b0, ok);  all_ok &= ok;
      repeat (3) @(posedge clk);
      #1;
      i_mem_ready = 1'b0;
      drive_pixel(32'd2, 32'd0, 1'b0, ok);  all_ok &= ok;
      @(posedge clk); #1;
      vectors++;
      if (!all_ok || o_pix_count !== 32'd1 || o_mem_we !== 1'b1 || o_mem_addr !== 17'd2) begin
         miscompares++;
         $display("FAIL abort_prep: accepted=%b pix=%0d we=%b addr=%0d, required 1 1 1 2",
                  all_ok, o_pix_count, o_mem_we, o_mem_addr);
      end
      do_start(8'h22);
      void'(exp_q.pop_back());
      vectors++;
      if (o_mem_we !== 1'b0 || o_pix_count !== 32'd0 || o_clip_count !== 32'd0 || o_mem_data !== 8'h22) begin
         miscompares++;
         $display("FAIL abort_clear: we=%b pix=%0d clip=%0d data=%h, required 0 0 0 22",
                  o_mem_we, o_pix_count, o_clip_count, o_mem_data);
      end
      i_mem_ready = 1'b1;
      drive_pixel(32'd100, 32'd0, 1'b0, ok);   all_ok &= ok;
      drive_pixel(32'd0, 32'd100, 1'b0, ok);   all_ok &= ok;
      drive_pixel(32'd200, 32'd200, 1'b0, ok); all_ok &= ok;
      raise_last;
      wait_done(50, ok);
      vectors++;
      if (!all_ok || !ok || o_pix_count !== 32'd3) begin
         miscompares++;
         $display("FAIL abort_frame: accepted=%b done=%b pix=%0d, required 1 1 3", all_ok, ok, o_pix_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (rd_n >= got_n) begin
            miscompares++;
            $display("FAIL abort_write: no write seen, required addr %0d", e[16:0]);
         end else begin
            if (got_addr[rd_n] !== e[16:0] || got_data[rd_n] !== e[24:17]) begin
               miscompares++;
               $display("FAIL abort_write: addr %0d data %h, required addr %0d data %h",
                        got_addr[rd_n], got_data[rd_n], e[16:0], e[24:17]);
            end
            rd_n++;
         end
      end
      vectors++;
      if (got_n != rd_n) begin
         miscompares++;
         $display("FAIL abort_extra: %0d writes seen, %0d required", got_n, rd_n);
         rd_n = got_n;
      end
   endtask

   task automatic test_last_together;
      bit ok, all_ok;
      logic [24:0] e;
      int before_n;
      all_ok = 1'b1;
      i_mem_ready = 1'b1;
      do_start(8'h77);
      before_n = got_n;
      drive_pixel(32'd7, 32'd3, 1'b0, ok);  all_ok &= ok;
      drive_pixel(32'd8, 32'd3, 1'b1, ok);  all_ok &= ok;
      vectors++;
      if (!all_ok || o_in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL last_drain: accepted=%b rdy=%b, required 1 0", all_ok, o_in_ready);
      end
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk); #1;
         if (o_done) ok = 1'b1;
      end
      vectors++;
      if (!ok || got_n - before_n != 2 || o_pix_count !== 32'd2) begin
         miscompares++;
         $display("FAIL last_done: done=%b writes_before_done=%0d pix=%0d, required 1 2 2",
                  ok, got_n - before_n, o_pix_count);
      end
      @(posedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (rd_n >= got_n) begin
            miscompares++;
            $display("FAIL last_write: no write seen, required addr %0d", e[16:0]);
         end else begin
            if (got_addr[rd_n] !== e[16:0] || got_data[rd_n] !== e[24:17]) begin
               miscompares++;
               $display("FAIL last_write: addr %0d data %h, required addr %0d data %h",
                        got_addr[rd_n], got_data[rd_n], e[16:0], e[24:17]);
            end
            rd_n++;
         end
      end
      vectors++;
      if (got_n != rd_n) begin
         miscompares++;
         $display("FAIL last_extra: %0d writes seen, %0d required", got_n, rd_n);
         rd_n = got_n;
      end
   endtask

   initial begin
      #12;
      test_reset();
      test_basic();
      test_clip();
      test_backpressure();
      test_abort();
      test_last_together();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
